arm_regfile_mp: RTL and testbench

- Parametrised successor to the core's single-write register file.
- Provides NRD combinational read ports, two write ports and R15 (PC+8) substitution on every read port.
- Write port 4 carries the high word of UMULL/SMULL.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard, so the multicycle multiplier and a future load unit can stall dependent reads.
- Sits in the datapath between decode operand fetch and writeback.

---
 rtl/arm_regfile_mp_pkg.sv | 17 +
 rtl/arm_regfile_mp_if.sv | 33 +++
 rtl/arm_regfile_mp_scoreboard.sv | 52 +++++
 rtl/arm_regfile_mp.sv | 79 +++++++
 tb/tb_arm_regfile_mp.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_regfile_mp_pkg.sv
// Shared core definitions for the multi-port ARM register file: default widths,
// PC index and the register-index type.
package arm_core_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int PC_IDX    = DEF_NREGS - 1;

  typedef logic [DEF_AW-1:0] reg_idx_t;

  // The PC is always the top architectural index and is never stored.
  function automatic int pc_idx(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/arm_regfile_mp_if.sv
// Operand-fetch / writeback bus of the multi-port register file.
interface arm_regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  parameter int NRD   = 3,
  parameter int AW    = $clog2(NREGS)
);
  // No valid/ready pair: reads are combinational with zero latency, and each
  // enable (we3, we4, pend_set) is a single-cycle strobe committed at the
  // rising edge it is sampled on; rd_busy tells the consumer to stall.
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic [XLEN-1:0]     r15;
  logic                we3;
  logic [AW-1:0]       a3;
  logic [XLEN-1:0]     wd3;
  logic                we4;
  logic [AW-1:0]       a4;
  logic [XLEN-1:0]     wd4;
  logic                pend_set;
  logic [AW-1:0]       pend_idx;

  modport master (
    output ra, r15, we3, a3, wd3, we4, a4, wd4, pend_set, pend_idx,
    input  rd, rd_busy
  );

  modport slave (
    input  ra, r15, we3, a3, wd3, we4, a4, wd4, pend_set, pend_idx,
    output rd, rd_busy
  );
endinterface

// File: rtl/arm_regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per stored register, set by a producer
// issue, cleared by a committed write, looked up per read port.
module regfile_scoreboard #(
  parameter int NREGS = 16,
  parameter int NRD   = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set,
  input  logic [AW-1:0]     i_set_idx,
  input  logic              i_clr_a,
  input  logic [AW-1:0]     i_clr_a_idx,
  input  logic              i_clr_b,
  input  logic [AW-1:0]     i_clr_b_idx,
  input  logic [NRD*AW-1:0] i_ra,
  input  logic [NRD-1:0]    i_fwd,
  output logic [NRD-1:0]    o_busy
);

  logic [NREGS-2:0] r_pend;
  logic [NREGS-2:0] w_pend_nxt;
  logic             w_set_ok;

  assign w_set_ok = i_set && (int'(i_set_idx) < NREGS - 1);

  // Set is applied after the clears so a new producer supersedes the old write.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NREGS - 1; i++) begin
      if (i_clr_a && int'(i_clr_a_idx) == i) w_pend_nxt[i] = 1'b0;
      if (i_clr_b && int'(i_clr_b_idx) == i) w_pend_nxt[i] = 1'b0;
      if (w_set_ok && int'(i_set_idx) == i)  w_pend_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  // PC and out-of-range indices match no entry and so read as not busy.
  always_comb begin
    o_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (int'(i_ra[k*AW +: AW]) == i) o_busy[k] = r_pend[i] && !i_fwd[k];
      end
    end
  end

endmodule

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: NRD combinational read ports with PC+8
// substitution, two write ports, optional write bypass and pending scoreboard.
module arm_regfile_mp
  import arm_core_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = 3,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input logic             clk,
  input logic             reset,
  arm_regfile_mp_if.slave bus
);

  localparam int PC = pc_idx(NREGS);

  logic [XLEN-1:0]     r_regs [NREGS-1];
  logic                w_we3;
  logic                w_we4;
  logic [NRD*XLEN-1:0] w_rd;
  logic [NRD-1:0]      w_fwd;

  // Writes to the PC or beyond the register count are dropped entirely.
  assign w_we3 = bus.we3 && (int'(bus.a3) < PC);
  assign w_we4 = bus.we4 && (int'(bus.a4) < PC);

  // Port 4 is written last so it wins an address collision with port 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) r_regs[i] <= '0;
    end else begin
      if (w_we3) r_regs[bus.a3] <= bus.wd3;
      if (w_we4) r_regs[bus.a4] <= bus.wd4;
    end
  end

  always_comb begin
    w_rd  = '0;
    w_fwd = '0;
    for (int k = 0; k < NRD; k++) begin
      if (int'(bus.ra[k*AW +: AW]) == PC) begin
        w_rd[k*XLEN +: XLEN] = bus.r15;
      end else if (int'(bus.ra[k*AW +: AW]) < PC) begin
        if (BYPASS != 0 && w_we4 && bus.a4 == bus.ra[k*AW +: AW]) begin
          w_rd[k*XLEN +: XLEN] = bus.wd4;
          w_fwd[k]             = 1'b1;
        end else if (BYPASS != 0 && w_we3 && bus.a3 == bus.ra[k*AW +: AW]) begin
          w_rd[k*XLEN +: XLEN] = bus.wd3;
          w_fwd[k]             = 1'b1;
        end else begin
          w_rd[k*XLEN +: XLEN] = r_regs[bus.ra[k*AW +: AW]];
        end
      end
    end
  end

  assign bus.rd = w_rd;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_set       (bus.pend_set),
    .i_set_idx   (bus.pend_idx),
    .i_clr_a     (w_we3),
    .i_clr_a_idx (bus.a3),
    .i_clr_b     (w_we4),
    .i_clr_b_idx (bus.a4),
    .i_ra        (bus.ra),
    .i_fwd       (w_fwd),
    .o_busy      (bus.rd_busy)
  );

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Directed bench for arm_regfile_mp: a bypassing and a non-bypassing instance
// share one stimulus stream; expectations are queued and checked at negedge.
module tb_arm_regfile_mp;
  import arm_core_pkg::*;

  localparam int XLEN = 32;
  localparam int NRD  = 3;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_regfile_mp_if #(.XLEN(XLEN), .NREGS(16), .NRD(NRD)) bus ();
  arm_regfile_mp_if #(.XLEN(XLEN), .NREGS(16), .NRD(NRD)) bus_nb ();

  assign bus_nb.ra       = bus.ra;
  assign bus_nb.r15      = bus.r15;
  assign bus_nb.we3      = bus.we3;
  assign bus_nb.a3       = bus.a3;
  assign bus_nb.wd3      = bus.wd3;
  assign bus_nb.we4      = bus.we4;
  assign bus_nb.a4       = bus.a4;
  assign bus_nb.wd4      = bus.wd4;
  assign bus_nb.pend_set = bus.pend_set;
  assign bus_nb.pend_idx = bus.pend_idx;

  arm_regfile_mp #(.XLEN(XLEN), .NREGS(16), .NRD(NRD), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  arm_regfile_mp #(.XLEN(XLEN), .NREGS(16), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb)
  );

  typedef struct {
    string           name;
    int              port;
    logic [XLEN-1:0] rd;
    logic            busy;
    logic [XLEN-1:0] rd_nb;
    logic            busy_nb;
  } exp_t;

  exp_t            exp_q [$];
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] mdl [0:14];

  // ---------------- driver tasks ----------------
  task automatic push(input string name, input int port, input logic [XLEN-1:0] rd,
                      input logic busy, input logic [XLEN-1:0] rd_nb, input logic busy_nb);
    exp_t e;
    e.name = name; e.port = port; e.rd = rd; e.busy = busy;
    e.rd_nb = rd_nb; e.busy_nb = busy_nb;
    exp_q.push_back(e);
  endtask

  task automatic push_same(input string name, input int port, input logic [XLEN-1:0] rd,
                           input logic busy);
    push(name, port, rd, busy, rd, busy);
  endtask

  task automatic set_ra(input int k, input int a);
    logic [AW-1:0] av;
    av = a[AW-1:0];
    bus.ra[k*AW +: AW] = av;
  endtask

  task automatic idle();
    bus.we3 = 1'b0; bus.a3 = '0; bus.wd3 = '0;
    bus.we4 = 1'b0; bus.a4 = '0; bus.wd4 = '0;
    bus.pend_set = 1'b0; bus.pend_idx = '0;
    bus.ra = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input string what, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", name, what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "rd",         bus.rd[e.port*XLEN +: XLEN],    e.rd);
      chk(e.name, "busy",       {31'd0, bus.rd_busy[e.port]},   {31'd0, e.busy});
      chk(e.name, "rd_nobyp",   bus_nb.rd[e.port*XLEN +: XLEN], e.rd_nb);
      chk(e.name, "busy_nobyp", {31'd0, bus_nb.rd_busy[e.port]}, {31'd0, e.busy_nb});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    bus.r15 = 32'h0000_0108;
    for (int i = 0; i < 15; i++) mdl[i] = '0;
    #1 reset = 1'b1;

    @(posedge clk); #1;
    set_ra(0, 5); set_ra(1, 15);
    push_same("in_reset_r5", 0, 32'h0, 1'b0);
    push_same("in_reset_pc", 1, 32'h108, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int a = 0; a < 15; a++) begin
      next_cycle();
      for (int k = 0; k < NRD; k++) begin
        set_ra(k, a);
        push_same("init_rd", k, 32'h0, 1'b0);
      end
    end
    next_cycle();
    for (int k = 0; k < NRD; k++) begin
      set_ra(k, 15);
      push_same("init_pc", k, 32'h108, 1'b0);
    end

    // Single write with same-cycle read of the target.
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd2; bus.wd3 = 32'hDEAD_BEEF; set_ra(0, 2);
    push("wr3_same", 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    next_cycle();
    mdl[2] = 32'hDEAD_BEEF;
    set_ra(0, 2);
    push_same("wr3_next", 0, mdl[2], 1'b0);

    // Dual independent writes.
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd4; bus.wd3 = 32'h11;
    bus.we4 = 1'b1; bus.a4 = 4'd5; bus.wd4 = 32'h22;
    set_ra(0, 4); set_ra(1, 5);
    push("dual_p3_same", 0, 32'h11, 1'b0, 32'h0, 1'b0);
    push("dual_p4_same", 1, 32'h22, 1'b0, 32'h0, 1'b0);
    next_cycle();
    mdl[4] = 32'h11; mdl[5] = 32'h22;
    set_ra(0, 4); set_ra(1, 5);
    push_same("dual_p3_next", 0, mdl[4], 1'b0);
    push_same("dual_p4_next", 1, mdl[5], 1'b0);

    // Address collision: port 4 wins.
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd6; bus.wd3 = 32'h66;
    bus.we4 = 1'b1; bus.a4 = 4'd6; bus.wd4 = 32'h77;
    set_ra(0, 6);
    push("coll_same", 0, 32'h77, 1'b0, 32'h0, 1'b0);
    next_cycle();
    mdl[6] = 32'h77;
    set_ra(0, 6);
    push_same("coll_next", 0, mdl[6], 1'b0);

    // Writes to the PC index are discarded.
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd15; bus.wd3 = 32'hFFFF_FFFF;
    bus.we4 = 1'b1; bus.a4 = 4'd15; bus.wd4 = 32'hEEEE_EEEE;
    set_ra(0, 15);
    push_same("pcw_same", 0, 32'h108, 1'b0);
    for (int a = 0; a < 15; a++) begin
      next_cycle();
      set_ra(2, a);
      push_same("pcw_sweep", 2, mdl[a], 1'b0);
    end

    // Pending set, then cleared by a port-4 write.
    next_cycle();
    bus.pend_set = 1'b1; bus.pend_idx = 4'd7; set_ra(1, 7);
    push_same("pend_pre", 1, 32'h0, 1'b0);
    next_cycle();
    set_ra(1, 7);
    push_same("pend_busy", 1, 32'h0, 1'b1);
    next_cycle();
    bus.we4 = 1'b1; bus.a4 = 4'd7; bus.wd4 = 32'h55; set_ra(1, 7);
    push("pend_fwd", 1, 32'h55, 1'b0, 32'h0, 1'b1);
    next_cycle();
    mdl[7] = 32'h55;
    set_ra(1, 7);
    push_same("pend_clr", 1, mdl[7], 1'b0);

    // Set and write to the same register: set wins, data still lands.
    next_cycle();
    bus.pend_set = 1'b1; bus.pend_idx = 4'd3;
    bus.we3 = 1'b1; bus.a3 = 4'd3; bus.wd3 = 32'h33; set_ra(2, 3);
    push("setwin_same", 2, 32'h33, 1'b0, 32'h0, 1'b0);
    next_cycle();
    set_ra(2, 3);
    push_same("setwin_next", 2, 32'h33, 1'b1);
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd3; bus.wd3 = 32'h34; set_ra(2, 3);
    push("p3clr_same", 2, 32'h34, 1'b0, 32'h33, 1'b1);
    next_cycle();
    set_ra(2, 3);
    push_same("p3clr_next", 2, 32'h34, 1'b0);

    // Asynchronous reset in the middle of a cycle with a write in flight.
    next_cycle();
    bus.pend_set = 1'b1; bus.pend_idx = 4'd7;
    bus.we3 = 1'b1; bus.a3 = 4'd9; bus.wd3 = 32'hAB;
    next_cycle();
    set_ra(0, 7); set_ra(1, 9);
    push_same("pre_rst_r7", 0, 32'h55, 1'b1);
    push_same("pre_rst_r9", 1, 32'hAB, 1'b0);
    next_cycle();
    bus.we3 = 1'b1; bus.a3 = 4'd10; bus.wd3 = 32'hCC;
    set_ra(0, 7); set_ra(1, 9); set_ra(2, 15);
    #1 reset = 1'b1;
    push_same("rst_r7", 0, 32'h0, 1'b0);
    push_same("rst_r9", 1, 32'h0, 1'b0);
    push_same("rst_pc", 2, 32'h108, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    set_ra(0, 10); set_ra(1, 7); set_ra(2, 9);
    push_same("lost_wr", 0, 32'h0, 1'b0);
    push_same("pend_cleared", 1, 32'h0, 1'b0);
    push_same("r9_cleared", 2, 32'h0, 1'b0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
